// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind datapath: code geometry, peg codes
// for the seven-segment converters, and the scorer state encoding.
package mastermind_pkg;

    localparam int COLOR_W = 3;
    localparam int NUM_POS = 4;

    localparam logic [1:0] FB_NONE    = 2'd0;
    localparam logic [1:0] FB_PARTIAL = 2'd1;
    localparam logic [1:0] FB_EXACT   = 2'd2;
    localparam logic [1:0] FB_BLANK   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXACT   = 2'd1,
        PARTIAL = 2'd2,
        PUBLISH = 2'd3
    } score_state_e;

endpackage

// File: rtl/peg_packer.sv
// Maps exact/partial counts onto four peg codes: exact pegs first, then
// partial pegs, then empty, so the pegs never reveal which slot matched.
module peg_packer
    import mastermind_pkg::*;
(
    input  logic [2:0] e_cnt,
    input  logic [2:0] p_cnt,
    output logic [1:0] fb0,
    output logic [1:0] fb1,
    output logic [1:0] fb2,
    output logic [1:0] fb3
);

    logic [3:0] exact_lim;
    logic [3:0] any_lim;
    logic [1:0] fb [NUM_POS];

    assign exact_lim = {1'b0, e_cnt};
    assign any_lim   = {1'b0, e_cnt} + {1'b0, p_cnt};

    always_comb begin
        fb = '{default: FB_NONE};
        for (int k = 0; k < NUM_POS; k++) begin
            if (4'(k) < exact_lim)
                fb[k] = FB_EXACT;
            else if (4'(k) < any_lim)
                fb[k] = FB_PARTIAL;
        end
    end

    assign fb0 = fb[0];
    assign fb1 = fb[1];
    assign fb2 = fb[2];
    assign fb3 = fb[3];

endmodule

// File: rtl/score_engine.sv
// Sequential Mastermind scorer: 4-cycle exact scan, 16-cycle partial scan,
// then a one-cycle publish of counts, peg codes and win/game-over status.
module score_engine
    import mastermind_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               last_turn,
    input  logic [COLOR_W-1:0] code0,
    input  logic [COLOR_W-1:0] code1,
    input  logic [COLOR_W-1:0] code2,
    input  logic [COLOR_W-1:0] code3,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    output logic               busy,
    output logic               done,
    output logic [2:0]         exact_count,
    output logic [2:0]         partial_count,
    output logic [1:0]         fb0,
    output logic [1:0]         fb1,
    output logic [1:0]         fb2,
    output logic [1:0]         fb3,
    output logic               win,
    output logic               game_over
);

    score_state_e state;
    score_state_e state_nxt;

    logic [COLOR_W-1:0] code_q  [NUM_POS];
    logic [COLOR_W-1:0] guess_q [NUM_POS];
    logic               last_turn_q;
    logic [NUM_POS-1:0] ex_mask;
    logic [NUM_POS-1:0] used_mask;
    logic [2:0]         e_cnt;
    logic [2:0]         p_cnt;
    logic [1:0]         i_idx;
    logic [1:0]         j_idx;
    logic               credited;

    logic               exact_hit;
    logic               partial_hit;
    logic               final_win;
    logic [1:0]         pk_fb0, pk_fb1, pk_fb2, pk_fb3;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = EXACT;
            EXACT:   if (i_idx == 2'd3) state_nxt = PARTIAL;
            PARTIAL: if (i_idx == 2'd3 && j_idx == 2'd3) state_nxt = PUBLISH;
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    assign exact_hit   = (guess_q[i_idx] == code_q[i_idx]);
    assign partial_hit = !credited && !ex_mask[i_idx] && !ex_mask[j_idx] &&
                         !used_mask[j_idx] && (guess_q[i_idx] == code_q[j_idx]);

    // NOTE: the working registers carry no reset; they are reloaded on every
    // accepted start and are never observed while the FSM sits in IDLE.
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: begin
                if (start) begin
                    code_q[0]   <= code0;
                    code_q[1]   <= code1;
                    code_q[2]   <= code2;
                    code_q[3]   <= code3;
                    guess_q[0]  <= guess0;
                    guess_q[1]  <= guess1;
                    guess_q[2]  <= guess2;
                    guess_q[3]  <= guess3;
                    last_turn_q <= last_turn;
                    ex_mask     <= '0;
                    used_mask   <= '0;
                    e_cnt       <= '0;
                    p_cnt       <= '0;
                    i_idx       <= '0;
                    j_idx       <= '0;
                    credited    <= 1'b0;
                end
            end
            EXACT: begin
                if (exact_hit) begin
                    ex_mask[i_idx] <= 1'b1;
                    e_cnt          <= e_cnt + 3'd1;
                end
                i_idx    <= i_idx + 2'd1;
                j_idx    <= '0;
                credited <= 1'b0;
            end
            PARTIAL: begin
                if (partial_hit) begin
                    used_mask[j_idx] <= 1'b1;
                    p_cnt            <= p_cnt + 3'd1;
                    credited         <= 1'b1;
                end
                j_idx <= j_idx + 2'd1;
                // Leaving the last code slot starts a fresh guess slot.
                if (j_idx == 2'd3) begin
                    i_idx    <= i_idx + 2'd1;
                    credited <= 1'b0;
                end
            end
            default: ;
        endcase
    end

    peg_packer u_peg_packer (
        .e_cnt (e_cnt),
        .p_cnt (p_cnt),
        .fb0   (pk_fb0),
        .fb1   (pk_fb1),
        .fb2   (pk_fb2),
        .fb3   (pk_fb3)
    );

    assign final_win = (e_cnt == 3'd4);

    // Published results hold between scans; only reset or a publish moves them.
    always_ff @(posedge clk) begin
        if (reset) begin
            done          <= 1'b0;
            exact_count   <= '0;
            partial_count <= '0;
            fb0           <= FB_BLANK;
            fb1           <= FB_BLANK;
            fb2           <= FB_BLANK;
            fb3           <= FB_BLANK;
            win           <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == PUBLISH) begin
                done          <= 1'b1;
                exact_count   <= e_cnt;
                partial_count <= p_cnt;
                fb0           <= pk_fb0;
                fb1           <= pk_fb1;
                fb2           <= pk_fb2;
                fb3           <= pk_fb3;
                win           <= final_win;
                game_over     <= final_win | last_turn_q;
            end
        end
    end

endmodule
